// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the request side and the forwarded-bus side of the memory bus
//   arbiter. clk and nReset are not part of the bundle.
//
//   Handshake: req[i] is a level request. Master i owns the bus (and may
//   drive dataBus) exactly while gnt[i] is high. Dropping req[i] releases
//   the bus at the next rising edge. A grant is never revoked while req[i]
//   stays high, except by the starvation guard, which pulses preempt.
//
//   Signals
//     req        master -> arbiter  per-master request
//     reqAddr    master -> arbiter  per-master address, slice i = [i*ADDR_W +: ADDR_W]
//     reqnRead   master -> arbiter  per-master read strobe, active-low
//     reqnWrite  master -> arbiter  per-master write strobe, active-low
//     gnt        arbiter -> master  one-hot grant or all zero
//     address    arbiter -> bus     owner's address, 0 when no owner
//     nRead      arbiter -> bus     owner's read strobe, 1 when no owner
//     nWrite     arbiter -> bus     owner's write strobe, 1 when no owner
//     busy       arbiter -> all     high while a master is granted
//     preempt    arbiter -> all     one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 16
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] reqAddr;
  logic [NREQ-1:0]        reqnRead;
  logic [NREQ-1:0]        reqnWrite;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      address;
  logic                   nRead;
  logic                   nWrite;
  logic                   busy;
  logic                   preempt;

  modport master (
    output req, reqAddr, reqnRead, reqnWrite,
    input  gnt, address, nRead, nWrite, busy, preempt
  );

  modport slave (
    input  req, reqAddr, reqnRead, reqnWrite,
    output gnt, address, nRead, nWrite, busy, preempt
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Round-robin arbiter for the shared memory bus. Grants one master at a
//   time, forwards the owner's address and strobes, and inserts a one-cycle
//   turnaround (TURN) between owners. dataBus and nReset are not touched.
//
//   Optional feature macro: MEM_BUS_ARB_STARVE_GUARD_EN
//     defined   : the owner is released after HOLD_MAX cycles in which some
//                 other master was waiting; preempt pulses during that TURN.
//     undefined : no hold counter; preempt is tied low.
//
//   Ports
//     clk          system clock, rising edge
//     nReset       synchronous active-low reset
//     bus          mem_bus_arbiter_if.slave (requests in, bus/grant out)
//     o_dbg_state  current FSM state (0 IDLE, 1 GRANT, 2 TURN)
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = 16,
  parameter int HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 nReset,
  mem_bus_arbiter_if.slave     bus,
  output logic [1:0]           o_dbg_state
);

  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PTR_W-1:0] r_owner, w_owner_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0] w_owner_inc;
  logic [PTR_W-1:0] w_winner;
  logic [PTR_W-1:0] w_off;
  logic [PTR_W:0]   w_sum;
  logic [NREQ-1:0]  w_req_rot;
  logic             w_any_req;
`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
  logic [7:0]       r_hcnt, w_hcnt_nxt;
  logic             r_preempt, w_preempt_nxt;
  logic             w_others;
`endif

  // Winner: rotate req so that index ptr sits at bit 0, take the lowest set
  // bit as an offset, then add ptr back modulo NREQ.
  always_comb begin
    w_req_rot = NREQ'({bus.req, bus.req} >> r_ptr);
    w_any_req = |bus.req;
    w_off     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_off = PTR_W'(k);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (PTR_W+1)'(NREQ)) w_sum = w_sum - (PTR_W+1)'(NREQ);
    w_winner = w_sum[PTR_W-1:0];
  end

  assign w_owner_inc = (r_owner == PTR_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
  assign w_others = |(bus.req & ~(NREQ'(1) << r_owner));
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
    w_hcnt_nxt    = r_hcnt;
    w_preempt_nxt = 1'b0;
`endif
    case (r_state)
      // TURN is the one-cycle gap; leaving it behaves exactly like IDLE.
      IDLE, TURN: begin
        if (w_any_req) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_winner;
`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
          w_hcnt_nxt  = 8'd0;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[r_owner]) begin
          w_state_nxt = TURN;
          w_ptr_nxt   = w_owner_inc;
        end
`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
        else if (w_others) begin
          // The waited cycle that brings hcnt to HOLD_MAX is the owner's last.
          w_hcnt_nxt = r_hcnt + 8'd1;
          if (w_hcnt_nxt == 8'(HOLD_MAX)) begin
            w_state_nxt   = TURN;
            w_ptr_nxt     = w_owner_inc;
            w_preempt_nxt = 1'b1;
          end
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus outputs decode from registered state and owner only.
  always_comb begin
    bus.gnt     = '0;
    bus.busy    = 1'b0;
    bus.address = '0;
    bus.nRead   = 1'b1;
    bus.nWrite  = 1'b1;
    if (r_state == GRANT) begin
      bus.gnt     = NREQ'(1) << r_owner;
      bus.busy    = 1'b1;
      bus.address = bus.reqAddr[r_owner*ADDR_W +: ADDR_W];
      bus.nRead   = bus.reqnRead[r_owner];
      bus.nWrite  = bus.reqnWrite[r_owner];
    end
`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
    bus.preempt = r_preempt;
`else
    bus.preempt = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
      r_hcnt    <= 8'd0;
      r_preempt <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
      r_hcnt    <= w_hcnt_nxt;
      r_preempt <= w_preempt_nxt;
`endif
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int NREQ     = 3;
  localparam int ADDR_W   = 16;
  localparam int HOLD_MAX = 4;
  localparam int EW       = NREQ + 4 + ADDR_W;
`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       nReset;
  logic [1:0] dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mem_bus_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus ();

  mem_bus_arbiter #(
    .NREQ    (NREQ),
    .ADDR_W  (ADDR_W),
    .HOLD_MAX(HOLD_MAX)
  ) u_dut (
    .clk        (clk),
    .nReset     (nReset),
    .bus        (bus.slave),
    .o_dbg_state(dbg_state)
  );

  // ---------------- stimulus state ----------------
  // nx_* is what the next tick applies; c_* is what the DUT currently sees.
  logic                   nx_nres, c_nres;
  logic [NREQ-1:0]        nx_req, c_req;
  logic [NREQ-1:0]        nx_nrd, c_nrd;
  logic [NREQ-1:0]        nx_nwr, c_nwr;
  logic [NREQ*ADDR_W-1:0] nx_addr, c_addr;

  // ---------------- reference model ----------------
  // m_own = -1 means nobody holds the bus (idle or turnaround).
  int   m_own;
  int   m_ptr;
  int   m_waited;
  logic m_pre;

  logic [EW-1:0] exp_q[$];
  int n_tests;
  int n_fail;

  // Effect of one rising edge given the inputs present at that edge.
  task automatic model_edge();
    logic [NREQ-1:0] others;
    if (!c_nres) begin
      m_own = -1; m_ptr = 0; m_waited = 0; m_pre = 1'b0;
      return;
    end
    m_pre = 1'b0;
    if (m_own < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (c_req[idx]) begin
          m_own = idx;
          m_waited = 0;
          break;
        end
      end
    end else if (!c_req[m_own]) begin
      m_ptr = (m_own + 1) % NREQ;
      m_own = -1;
    end else if (GUARD) begin
      others = c_req;
      others[m_own] = 1'b0;
      if (others != '0) begin
        m_waited++;
        if (m_waited >= HOLD_MAX) begin
          m_ptr = (m_own + 1) % NREQ;
          m_own = -1;
          m_pre = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [EW-1:0] expect_outputs();
    logic [NREQ-1:0]   g;
    logic [ADDR_W-1:0] a;
    logic              nr, nw, b;
    g = '0; a = '0; nr = 1'b1; nw = 1'b1; b = 1'b0;
    if (m_own >= 0) begin
      g[m_own] = 1'b1;
      b  = 1'b1;
      a  = c_addr[m_own*ADDR_W +: ADDR_W];
      nr = c_nrd[m_own];
      nw = c_nwr[m_own];
    end
    return {g, b, m_pre, nr, nw, a};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_inputs();
    c_nres = nx_nres; c_req = nx_req; c_nrd = nx_nrd; c_nwr = nx_nwr; c_addr = nx_addr;
    nReset        = c_nres;
    bus.req       = c_req;
    bus.reqnRead  = c_nrd;
    bus.reqnWrite = c_nwr;
    bus.reqAddr   = c_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    apply_inputs();
    exp_q.push_back(expect_outputs());
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    nx_nres = 1'b0;
    tick();
    nx_nres = 1'b1;
  endtask

  task automatic randomize_master(input int i);
    case ($urandom_range(0, 2))
      0:       begin nx_nrd[i] = 1'b0; nx_nwr[i] = 1'b1; end
      1:       begin nx_nrd[i] = 1'b1; nx_nwr[i] = 1'b0; end
      default: begin nx_nrd[i] = 1'b1; nx_nwr[i] = 1'b1; end
    endcase
    nx_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {bus.gnt, bus.busy, bus.preempt, bus.nRead, bus.nWrite, bus.address};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL bus_outputs t=%0t state=%0d got gnt=%b busy=%b pre=%b nRd=%b nWr=%b addr=%h expected gnt=%b busy=%b pre=%b nRd=%b nWr=%b addr=%h",
                   $time, dbg_state,
                   a[EW-1 -: NREQ], a[ADDR_W+3], a[ADDR_W+2], a[ADDR_W+1], a[ADDR_W], a[ADDR_W-1:0],
                   e[EW-1 -: NREQ], e[ADDR_W+3], e[ADDR_W+2], e[ADDR_W+1], e[ADDR_W], e[ADDR_W-1:0]);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_own = -1; m_ptr = 0; m_waited = 0; m_pre = 1'b0;
    nx_nres = 1'b0;
    nx_req  = '1;
    nx_nrd  = '1;
    nx_nwr  = '1;
    nx_addr = '0;
    apply_inputs();

    // Reset held two cycles with every master requesting.
    ticks(2);

    // Single master 1 read at 0x1000, then release.
    nx_nres = 1'b1;
    nx_req  = '0;
    tick();
    nx_req = 3'b010;
    nx_addr[1*ADDR_W +: ADDR_W] = 16'h1000;
    nx_nrd[1] = 1'b0;
    ticks(3);
    nx_req = '0;
    nx_nrd = '1;
    ticks(3);

    // Contention from reset: 0 wins, drops, TURN, then 1.
    do_reset();
    nx_req = 3'b011;
    nx_addr[0*ADDR_W +: ADDR_W] = 16'h0A0A;
    nx_nwr[0] = 1'b0;
    ticks(2);
    nx_req = 3'b010;
    ticks(4);
    nx_req = '0;
    nx_nwr = '1;
    ticks(2);

    // Starvation: master 0 holds while master 1 waits.
    do_reset();
    nx_req = 3'b001;
    ticks(3);
    nx_req = 3'b011;
    ticks(HOLD_MAX + 8);
    nx_req = '0;
    ticks(2);

    // All masters requesting continuously.
    do_reset();
    nx_req = 3'b111;
    ticks(20);
    nx_req = '0;
    ticks(2);

    // Reset while master 2 owns the bus.
    do_reset();
    nx_req = 3'b100;
    nx_addr[2*ADDR_W +: ADDR_W] = 16'hBEEF;
    nx_nrd[2] = 1'b0;
    ticks(4);
    nx_nres = 1'b0;
    nx_req  = 3'b111;
    tick();
    nx_nres = 1'b1;
    ticks(5);
    nx_req = '0;
    nx_nrd = '1;
    ticks(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < NREQ; i++) randomize_master(i);
    repeat (600) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 5) == 0) nx_req[i] = ~nx_req[i];
        if ($urandom_range(0, 3) == 0) randomize_master(i);
      end
      nx_nres = ($urandom_range(0, 79) != 0);
      tick();
    end

    nx_nres = 1'b1;
    nx_req  = '0;
    ticks(3);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d pending entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the shared 256-bit memory bus (data, address, nRead, nWrite) between up to four bus masters, such as the execution engine, a program loader and a debug port. It grants exactly one master at a time in round-robin order. It also forwards that master's address and strobes onto the bus and inserts a one-cycle turnaround between owners. The arbiter never touches dataBus or the shared nReset line. A master drives dataBus only while its grant bit is high.

## Interface
- NREQ, 2: number of masters; legal range 2..4.
- ADDR_W, 16: address width.
- HOLD_MAX, 8: maximum grant cycles while another master waits (starvation guard only); legal range 1..255.
- clk  in  1  system clock; all state changes on the rising edge.
- nReset  in  1  reset; one clock; reset is synchronous and active-low.
- req  in  NREQ  request; bit i high means master i wants the bus.
- reqAddr  in  NREQ*ADDR_W  per-master address; slice i is bits [i*ADDR_W +: ADDR_W].
- reqnRead  in  NREQ  per-master active-low read strobe.
- reqnWrite  in  NREQ  per-master active-low write strobe.
- gnt  out  NREQ  one-hot grant, or all zero.
- address  out  ADDR_W  bus address.
- nRead  out  1  bus read strobe, active-low.
- nWrite  out  1  bus write strobe, active-low.
- busy  out  1  high while any master is granted.
- preempt  out  1  one-cycle pulse when an owner is forcibly released.

## Operation
- States: IDLE, GRANT, TURN. Registers: owner index, round-robin pointer ptr, hold counter hcnt (8 bits).
- Reset values: state=IDLE, gnt=0, ptr=0, hcnt=0, busy=0, preempt=0, nRead=1, nWrite=1, address=0.
- Winner selection: scan from index ptr upward, wrapping modulo NREQ. The first i with req[i]=1 wins.
- IDLE: if any req is high, load owner=winner, set hcnt=0 and go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - gnt[owner]=1, busy=1.
  - address=reqAddr[owner], nRead=reqnRead[owner], nWrite=reqnWrite[owner].
  - If req[owner]=0, go to TURN and set ptr=(owner+1) mod NREQ.
  - Otherwise stay in GRANT (subject to the guard in Configuration).
- TURN: lasts exactly one cycle, with gnt=0, busy=0, nRead=nWrite=1, address=0. Then behave as IDLE: a pending winner moves to GRANT, otherwise go to IDLE.
- Outside GRANT: address=0, nRead=1, nWrite=1. The outputs are never left at z.
- A master must not assert both reqnRead and reqnWrite low at once. The arbiter forwards them unchanged and does no checking.
- Requests from non-owners in GRANT have no effect beyond hcnt counting.

## Timing
- Grant latency: req[i] high before edge k with the bus idle gives gnt[i]=1 after edge k (one cycle).
- Release: req[owner] falls before edge k. gnt=0 after edge k (TURN), and the next owner is granted after edge k+1. Minimum handover is 2 cycles.
- address, nRead and nWrite are combinational from the owner register and the registered state. They change only with gnt or with the owner's own inputs.
- preempt is registered. It is high for exactly the one cycle coinciding with the TURN that follows a forced release.
- Reset mid-GRANT: the next cycle shows the reset values. ptr returns to 0.
- Simultaneous release and new request (req[owner] falls while others rise): TURN still occurs.
- Requests from all masters at once: the master at index ptr wins. Immediately after reset, master 0 wins.

## Configuration
- MEM_BUS_ARB_STARVE_GUARD_EN defined:
  - In GRANT, hcnt increments each cycle in which any non-owner req is high. It holds when no other master is waiting.
  - When hcnt reaches HOLD_MAX, the next edge forces TURN with preempt=1 and sets ptr=(owner+1) mod NREQ.
  - hcnt clears on entry to GRANT.
- Not defined: hcnt is removed, preempt is tied 0, and the owner keeps the bus for as long as req[owner] stays high.

## Test plan
- Reset: nReset=0 for 2 cycles with req=all ones gives gnt=0, busy=0, nRead=nWrite=1, address=0, preempt=0.
- Single master: req[1]=1, reqAddr[1]=0x1000, reqnRead[1]=0. One cycle later expect gnt=0b10, address=0x1000, nRead=0. Drop req[1] and expect gnt=0 with nRead=1 the following cycle.
- Contention: req=0b11 from reset gives gnt=0b01. Drop req[0] and expect one TURN cycle with gnt=0, then gnt=0b10.
- Starvation guard (macro defined, HOLD_MAX=8): hold req[0] while req[1] rises. After 8 counted cycles expect preempt=1 with gnt=0 for one cycle, then gnt=0b10. With the macro undefined, gnt stays 0b01 indefinitely.
- Round-robin (NREQ=3, macro defined, HOLD_MAX=2, all req held): the owner sequence is 0,1,2,0, with each grant lasting 2 cycles and separated by one TURN.
- Reset mid-grant: master 2 is owner and nReset=0 for one cycle. Expect all reset values next cycle, then with req=0b111, gnt=0b001.
